ins_prefetch_queue: RTL and testbench
=====================================

INS_PREFETCH_QUEUE -- requirements
Module: ins_prefetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, which sets the queue entry count (power of two, 2..8).
REQ-002 The block SHALL have parameter ADDRSIZE, default 12, which sets the instruction address width.
REQ-003 The block SHALL have parameter WIDTH, default 32, which sets the instruction width.
REQ-004 The block SHALL have port clk, input, width 1, the clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1, an asynchronous active-high reset.
REQ-006 The block SHALL have port cpu_addr, input, width ADDRSIZE, the core program counter (INS_ADDR).
REQ-007 The block SHALL have port cpu_ins, output, width WIDTH, the instruction presented to the core (INS_MEM).
REQ-008 The block SHALL have port cpu_valid, output, width 1, asserted when cpu_ins holds the instruction at cpu_addr.
REQ-009 The block SHALL have port mem_req, output, width 1, the instruction-memory read request.
REQ-010 The block SHALL have port mem_addr, output, width ADDRSIZE, the instruction-memory read address.
REQ-011 The block SHALL have port mem_ack, input, width 1, asserted for one cycle when mem_rdata is valid.
REQ-012 The block SHALL have port mem_rdata, input, width WIDTH, the instruction-memory read data.

Function
REQ-013 The queue SHALL hold up to DEPTH entries, each an {address, instruction} pair, in strictly sequential address order with 12-bit wrap (4095 is followed by 0).
REQ-014 The hit condition SHALL be count>0 and head address == cpu_addr.
REQ-015 On a hit, cpu_ins SHALL equal the head instruction combinationally; otherwise cpu_ins SHALL be 0 (NOP) and cpu_valid SHALL be 0.
REQ-016 When count>0 and cpu_addr == head address+1 (mod 2^ADDRSIZE), the head SHALL be popped at the next edge.
REQ-017 When cpu_addr matches neither the head address nor head address+1, or when count==0 and cpu_addr != fetch_addr, a flush SHALL occur: count=0 and fetch_addr=cpu_addr at the next edge.
REQ-018 The fetch FSM SHALL have states IDLE, REQ and DROP.
REQ-019 IDLE SHALL go to REQ when count+pending < DEPTH and no flush is occurring; on entry mem_addr=fetch_addr and mem_req=1.
REQ-020 In REQ, mem_req and mem_addr SHALL be held stable until mem_ack.
REQ-021 In REQ, on mem_ack the block SHALL push {mem_addr, mem_rdata} and increment fetch_addr; the next state SHALL be REQ (new address) if space remains, else IDLE.
REQ-022 If a flush occurs in REQ without mem_ack, the FSM SHALL go to DROP, keeping mem_req and the stale mem_addr asserted.
REQ-023 In DROP, on mem_ack the data SHALL be discarded and the FSM SHALL go to REQ with mem_addr=fetch_addr (the post-flush address).
REQ-024 A flush coincident with mem_ack in REQ SHALL discard that data and SHALL not push it.
REQ-025 A pop and a push in the same cycle SHALL leave count unchanged; a push SHALL never occur when count==DEPTH.
REQ-026 Miss-to-valid latency SHALL be 1 cycle (flush) + 1 cycle (request) + memory latency, i.e. cpu_valid rises the cycle after the first mem_ack.
REQ-027 The block SHALL impose no write path; mem_req is read-only.

Reset
REQ-028 Asserting rst SHALL immediately set count=0, fetch_addr=0, state=IDLE, mem_req=0, mem_addr=0, cpu_ins=0 and cpu_valid=0.
REQ-029 Reset mid-handshake SHALL abandon the request; a later stale mem_ack in IDLE SHALL be ignored.

Configuration
REQ-030 Macro IPQ_FLUSH_COUNT_EN, when defined, SHALL add output flush_cnt [15:0], which increments on each flush, saturates at 16'hFFFF and resets to 0.
REQ-031 When IPQ_FLUSH_COUNT_EN is not defined, the flush_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then hold cpu_addr=0 with a 1-cycle-ack memory -> mem_addr 0,1,2,3 requested; the queue fills to 4, then mem_req=0; cpu_valid=1 with cpu_ins=mem[0].
REQ-033 Sequential run, cpu_addr stepping 0..9 per cycle with 1-cycle ack -> cpu_valid stays 1 after initial fill; each cpu_ins=mem[cpu_addr]; no flushes.
REQ-034 Branch from cpu_addr=3 to 12'h100 while a request is outstanding with 3-cycle ack -> DROP is entered and the stale data is not pushed; the next request is mem_addr=12'h100; cpu_ins=mem[0x100] once valid.
REQ-035 Wrap case, cpu_addr=12'hFFE stepping -> fetches FFE, FFF, 000, 001 in order; no flush occurs at the wrap.
REQ-036 Assert rst while mem_req=1 in REQ, then deliver mem_ack -> mem_req=0 at once; the ack is ignored and count stays 0.
REQ-037 With IPQ_FLUSH_COUNT_EN defined, 3 branches -> flush_cnt=3; after rst, flush_cnt=0.

Source files
------------

// File: rtl/ins_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential instructions ahead of the core and flushes on a branch.
// Optional macro IPQ_FLUSH_COUNT_EN adds a saturating flush counter output (flush_cnt).
module ins_prefetch_queue #(
    parameter int DEPTH    = 4,
    parameter int ADDRSIZE = 12,
    parameter int WIDTH    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDRSIZE-1:0] cpu_addr,
    output logic [WIDTH-1:0]    cpu_ins,
    output logic                cpu_valid,
    output logic                mem_req,
    output logic [ADDRSIZE-1:0] mem_addr,
    input  logic                mem_ack,
`ifdef IPQ_FLUSH_COUNT_EN
    output logic [15:0]         flush_cnt,
`endif
    input  logic [WIDTH-1:0]    mem_rdata
);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    state_t state_reg, state_next;

    logic [ADDRSIZE-1:0] addr_q [DEPTH];
    logic [WIDTH-1:0]    ins_q  [DEPTH];

    logic [PTRW-1:0]     rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
    logic [CNTW-1:0]     count_reg, count_next, cnt_push;
    logic [ADDRSIZE-1:0] fetch_addr_reg, fetch_addr_next;
    logic [ADDRSIZE-1:0] mem_addr_reg, mem_addr_next;

    logic [ADDRSIZE-1:0] head_addr, head_addr_inc;
    logic [WIDTH-1:0]    head_ins;
    logic                not_empty, hit, pop, flush, push;

    assign head_addr     = addr_q[rd_ptr_reg];
    assign head_ins      = ins_q[rd_ptr_reg];
    assign head_addr_inc = head_addr + ADDRSIZE'(1);

    // The core either sits on the head, has moved one past it (consume), or has branched.
    always_comb begin
        not_empty = (count_reg != '0);
        hit       = not_empty && (head_addr == cpu_addr);
        pop       = not_empty && (head_addr_inc == cpu_addr);
        flush     = not_empty ? (!hit && !pop) : (cpu_addr != fetch_addr_reg);
    end

    assign cpu_valid = hit;
    assign cpu_ins   = hit ? head_ins : '0;
    assign mem_req   = (state_reg != IDLE);
    assign mem_addr  = mem_addr_reg;

    // Occupancy after a push this cycle, used to decide whether to keep requesting.
    assign cnt_push = count_reg + CNTW'(1) - CNTW'(pop);

    always_comb begin
        state_next      = state_reg;
        fetch_addr_next = flush ? cpu_addr : fetch_addr_reg;
        mem_addr_next   = mem_addr_reg;
        push            = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!flush && (count_reg < DEPTH_C)) begin
                    state_next    = REQ;
                    mem_addr_next = fetch_addr_reg;
                end
            end
            REQ: begin
                if (flush) begin
                    if (mem_ack) begin
                        // Returning data belongs to the old stream; restart at the branch target.
                        state_next    = REQ;
                        mem_addr_next = cpu_addr;
                    end else begin
                        state_next = DROP;
                    end
                end else if (mem_ack) begin
                    push            = 1'b1;
                    fetch_addr_next = fetch_addr_reg + ADDRSIZE'(1);
                    if (cnt_push < DEPTH_C) begin
                        state_next    = REQ;
                        mem_addr_next = fetch_addr_reg + ADDRSIZE'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_next    = REQ;
                    mem_addr_next = fetch_addr_next;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next  = count_reg + CNTW'(push) - CNTW'(pop);
        rd_ptr_next = rd_ptr_reg + PTRW'(pop);
        wr_ptr_next = wr_ptr_reg + PTRW'(push);
        if (flush) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            fetch_addr_reg <= '0;
            mem_addr_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            fetch_addr_reg <= fetch_addr_next;
            mem_addr_reg   <= mem_addr_next;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_reg] <= mem_addr_reg;
            ins_q[wr_ptr_reg]  <= mem_rdata;
        end
    end

`ifdef IPQ_FLUSH_COUNT_EN
    logic [15:0] flush_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_reg <= '0;
        end else if (flush && (flush_cnt_reg != 16'hFFFF)) begin
            flush_cnt_reg <= flush_cnt_reg + 16'd1;
        end
    end

    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_ins_prefetch_queue.sv
// Self-checking bench for ins_prefetch_queue: directed scenarios plus random core/memory behaviour
// checked every cycle against a queue-based reference model.
module tb_ins_prefetch_queue;
    localparam int D  = 4;
    localparam int AW = 12;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cpu_addr;
    logic [W-1:0]  cpu_ins;
    logic          cpu_valid;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [W-1:0]  mem_rdata;
`ifdef IPQ_FLUSH_COUNT_EN
    logic [15:0]   flush_cnt;
`endif

    ins_prefetch_queue #(.DEPTH(D), .ADDRSIZE(AW), .WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_addr (cpu_addr),
        .cpu_ins  (cpu_ins),
        .cpu_valid(cpu_valid),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
`ifdef IPQ_FLUSH_COUNT_EN
        .flush_cnt(flush_cnt),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction memory and responder
    logic [W-1:0] mem [1 << AW];
    int           lat;
    int           rcnt;
    bit           force_ack;

    // Reference model: queue of {address, instruction} plus outstanding-request bookkeeping
    typedef struct {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } ent_t;
    ent_t          q[$];
    logic [AW-1:0] m_fetch;
    logic [AW-1:0] m_raddr;
    bit            m_active;
    bit            m_drop;
    int            m_flushes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [AW-1:0] a);
        return (q.size() > 0) && (q[0].a == a);
    endfunction

    task automatic model_reset();
        q.delete();
        m_fetch   = '0;
        m_raddr   = '0;
        m_active  = 0;
        m_drop    = 0;
        m_flushes = 0;
        rcnt      = 0;
    endtask

    task automatic model_update(input bit ack, input logic [W-1:0] data);
        int            sz;
        bit            flush;
        bit            popv;
        bit            acked;
        logic [AW-1:0] nxt;
        sz    = q.size();
        popv  = 0;
        if (sz > 0) begin
            nxt   = q[0].a + 12'd1;
            popv  = (cpu_addr == nxt);
            flush = (cpu_addr != q[0].a) && !popv;
        end else begin
            flush = (cpu_addr != m_fetch);
        end
        if (flush && m_flushes < 65535) m_flushes++;
        acked = m_active && ack;
        if (popv) void'(q.pop_front());
        if (acked && !m_drop && !flush) begin
            q.push_back('{m_raddr, data});
            m_fetch = m_fetch + 12'd1;
        end
        if (flush) begin
            q.delete();
            m_fetch = cpu_addr;
        end
        if (m_active) begin
            if (!acked) begin
                if (flush) m_drop = 1;
            end else if (m_drop || flush) begin
                m_drop  = 0;
                m_raddr = m_fetch;
            end else if (q.size() < D) begin
                m_raddr = m_fetch;
            end else begin
                m_active = 0;
            end
        end else if (!flush && sz < D) begin
            m_active = 1;
            m_raddr  = m_fetch;
        end
    endtask

    // One clock cycle: respond to memory, compare at negedge, advance model at the edge.
    task automatic step();
        bit           ack;
        logic [W-1:0] data;
        bit           e_valid;
        logic [W-1:0] e_ins;
        ack  = 0;
        data = $urandom();
        if (force_ack) begin
            ack = 1;
        end else if (mem_req) begin
            if (rcnt >= lat) begin
                ack  = 1;
                rcnt = 0;
                data = mem[mem_addr];
            end else begin
                rcnt++;
            end
        end
        mem_ack   = ack;
        mem_rdata = data;
        @(negedge clk);
        e_valid = model_hit(cpu_addr);
        e_ins   = e_valid ? q[0].d : '0;
        check("cpu_valid", cpu_valid, e_valid);
        check("cpu_ins", cpu_ins, e_ins);
        check("mem_req", mem_req, m_active);
        if (m_active) check("mem_addr", mem_addr, m_raddr);
        if (e_valid) check("ins_vs_mem", cpu_ins, mem[cpu_addr]);
`ifdef IPQ_FLUSH_COUNT_EN
        check("flush_cnt", flush_cnt, m_flushes);
`endif
        @(posedge clk);
        model_update(ack, data);
        #1;
    endtask

    // Core that advances its PC after each cycle in which it received a valid instruction.
    task automatic run_core(input logic [AW-1:0] stop_addr, input int budget);
        int  n;
        bit  v;
        n = 0;
        while (cpu_addr != stop_addr && n < budget) begin
            v = model_hit(cpu_addr);
            step();
            if (v) cpu_addr = cpu_addr + 12'd1;
            n++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        rst       = 1'b1;
        cpu_addr  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        lat       = 1;
        force_ack = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom();
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", cpu_valid, 1'b0);
        check("rst_ins", cpu_ins, '0);
        check("rst_req", mem_req, 1'b0);
        check("rst_addr", mem_addr, '0);
`ifdef IPQ_FLUSH_COUNT_EN
        check("rst_flush_cnt", flush_cnt, 16'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // Hold PC at 0: queue fills to DEPTH then requests stop
        repeat (24) step();
        check("fill_valid", cpu_valid, 1'b1);
        check("fill_ins", cpu_ins, mem[0]);
        check("fill_req", mem_req, 1'b0);

        // Sequential run 0..9
        run_core(12'd10, 200);

        // Branch to 0x100 while a request is outstanding, 3-cycle memory
        lat      = 3;
        cpu_addr = 12'd3;
        n = 0;
        while (!(model_hit(12'd3) && m_active && !m_drop && rcnt < lat) && n < 100) begin
            step();
            n++;
        end
        cpu_addr = 12'h100;
        step();
        check("drop_req_held", mem_req, 1'b1);
        n = 0;
        while (!model_hit(12'h100) && n < 100) begin
            step();
            n++;
        end
        check("branch_valid", cpu_valid, 1'b1);
        check("branch_ins", cpu_ins, mem[12'h100]);

        // Address wrap FFE -> 002
        lat      = 1;
        cpu_addr = 12'hFFE;
        run_core(12'h003, 200);

        // Random core and memory behaviour
        for (int i = 0; i < 400; i++) begin
            bit v;
            lat = $urandom_range(0, 3);
            v   = model_hit(cpu_addr);
            step();
            r = $urandom_range(0, 9);
            if (v && r < 7) cpu_addr = cpu_addr + 12'd1;
            else if (r == 8) cpu_addr = 12'h400 + 12'($urandom_range(0, 15));
            else if (r == 9) cpu_addr = cpu_addr + 12'd1;
        end

        // Reset in the middle of a handshake, then a stale ack
        lat      = 3;
        cpu_addr = 12'h200;
        n = 0;
        while (!(m_active && rcnt < lat && rcnt > 0) && n < 100) begin
            step();
            n++;
        end
        mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_req", mem_req, 1'b0);
        check("midrst_addr", mem_addr, '0);
        check("midrst_valid", cpu_valid, 1'b0);
        check("midrst_ins", cpu_ins, '0);
`ifdef IPQ_FLUSH_COUNT_EN
        check("midrst_flush_cnt", flush_cnt, 16'd0);
`endif
        model_reset();
        cpu_addr = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        force_ack = 1;
        step();
        force_ack = 0;
        check("stale_ack_valid", cpu_valid, 1'b0);
        repeat (12) step();
        check("post_rst_ins", cpu_ins, mem[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
